// File: rtl/req_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : req_encoder_seq
// Description : Sequential 16-to-4 encoder. Captures a multi-hot request
//               vector and streams out the index of every set bit, lowest
//               index first, one code per valid/ready transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module req_encoder_seq #(
   parameter int WIDTH  = 16,   // must equal 2**CODE_W
   parameter int CODE_W = 4
) (
   input  logic              clk_in,
   input  logic              rstn_in,
   input  logic [WIDTH-1:0]  req_in,
   input  logic              load_in,
   input  logic              flush_in,
   input  logic              ready_in,
   output logic [CODE_W-1:0] code_out,
   output logic              valid_out,
   output logic              busy_out,
   output logic [CODE_W:0]   count_out,
   output logic              zero_out
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [WIDTH-1:0]  r_pending;
   logic [WIDTH-1:0]  w_pending_nxt;
   logic [WIDTH-1:0]  w_pending_clr;
   logic [CODE_W:0]   r_count;
   logic [CODE_W:0]   w_count_nxt;
   logic [CODE_W:0]   w_pop;
   logic              r_zero;
   logic              w_zero_nxt;
   logic [CODE_W-1:0] w_low_idx;

   // Index of the lowest set bit of the pending vector (0 when empty).
   always_comb begin
      w_low_idx = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (r_pending[i]) begin
            w_low_idx = CODE_W'(i);
         end
      end
   end

   // Population count of the incoming request vector.
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_pop = w_pop + {{CODE_W{1'b0}}, req_in[i]};
      end
   end

   // Pending vector with its lowest set bit removed (x & (x-1)).
   assign w_pending_clr = r_pending & (r_pending - WIDTH'(1));

   // Next-state and datapath update; flush overrides load and transfer.
   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_count_nxt   = r_count;
      w_zero_nxt    = 1'b0;
      if (flush_in) begin
         w_state_nxt   = ST_IDLE;
         w_pending_nxt = '0;
         w_count_nxt   = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load_in) begin
                  if (req_in != '0) begin
                     w_pending_nxt = req_in;
                     w_count_nxt   = w_pop;
                     w_state_nxt   = ST_DRAIN;
                  end else begin
                     w_zero_nxt  = 1'b1;
                     w_count_nxt = '0;
                  end
               end
            end
            ST_DRAIN: begin
               // load_in is deliberately ignored here, even on the final transfer
               if (ready_in) begin
                  w_pending_nxt = w_pending_clr;
                  if (w_pending_clr == '0) begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            default: begin
               w_state_nxt   = ST_IDLE;
               w_pending_nxt = '0;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk_in or negedge rstn_in) begin
      if (!rstn_in) begin
         r_state   <= ST_IDLE;
         r_pending <= '0;
         r_count   <= '0;
         r_zero    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_count   <= w_count_nxt;
         r_zero    <= w_zero_nxt;
      end
   end

   // Outputs derive only from registered state; no input-to-output path.
   assign code_out  = w_low_idx;
   assign valid_out = (r_state == ST_DRAIN);
   assign busy_out  = (r_state == ST_DRAIN);
   assign count_out = r_count;
   assign zero_out  = r_zero;

endmodule
`default_nettype wire

// File: tb/tb_req_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_req_encoder_seq
// Description : Self-checking bench for req_encoder_seq; directed scenarios
//               followed by random traffic against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_req_encoder_seq;

   logic        clk_in = 1'b0;
   logic        rstn_in;
   logic [15:0] req_in;
   logic        load_in;
   logic        flush_in;
   logic        ready_in;
   logic [3:0]  code_out;
   logic        valid_out;
   logic        busy_out;
   logic [4:0]  count_out;
   logic        zero_out;

   int checks   = 0;
   int failures = 0;

   // Reference model: queue of codes still to be emitted.
   int q[$];
   int m_count;
   bit m_zero;

   req_encoder_seq #(.WIDTH(16), .CODE_W(4)) dut (
      .clk_in    (clk_in),
      .rstn_in   (rstn_in),
      .req_in    (req_in),
      .load_in   (load_in),
      .flush_in  (flush_in),
      .ready_in  (ready_in),
      .code_out  (code_out),
      .valid_out (valid_out),
      .busy_out  (busy_out),
      .count_out (count_out),
      .zero_out  (zero_out)
   );

   // Free-running clock.
   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_count = 0;
      m_zero  = 0;
   endtask

   task automatic check_model(input string tag);
      bit exp_v;
      exp_v = (q.size() > 0);
      check({tag, ".valid"}, valid_out, exp_v);
      check({tag, ".busy"},  busy_out,  exp_v);
      check({tag, ".code"},  code_out,  exp_v ? q[0] : 0);
      check({tag, ".count"}, count_out, m_count);
      check({tag, ".zero"},  zero_out,  m_zero);
   endtask

   // One clock cycle: drive inputs, update model at the edge, compare at negedge.
   task automatic step(input bit ld, input logic [15:0] rq, input bit fl,
                       input bit rdy, input string tag);
      load_in  = ld;
      req_in   = rq;
      flush_in = fl;
      ready_in = rdy;
      @(posedge clk_in);
      if (fl) begin
         q.delete();
         m_count = 0;
         m_zero  = 0;
      end else if (q.size() == 0) begin
         m_zero = 0;
         if (ld) begin
            m_count = $countones(rq);
            if (rq == 16'h0) m_zero = 1;
            for (int b = 0; b < 16; b++) if (rq[b]) q.push_back(b);
         end
      end else begin
         m_zero = 0;
         if (rdy) void'(q.pop_front());
      end
      @(negedge clk_in);
      check_model(tag);
   endtask

   initial begin
      rstn_in  = 1'b0;
      req_in   = '0;
      load_in  = 1'b0;
      flush_in = 1'b0;
      ready_in = 1'b0;
      model_reset();
      repeat (2) @(negedge clk_in);
      check_model("rst");
      rstn_in = 1'b1;

      // Three-bit request drains in three consecutive cycles.
      step(1, 16'h1011, 0, 1, "ld1011");
      check("c1011", count_out, 3);
      check("code0", code_out, 0);
      step(0, 16'h0, 0, 1, "d1");
      check("code4", code_out, 4);
      step(0, 16'h0, 0, 1, "d2");
      check("code12", code_out, 12);
      step(0, 16'h0, 0, 1, "d3");
      check("busy_end", busy_out, 0);

      // Back-pressure holds code and valid stable.
      step(1, 16'h8000, 0, 0, "ld8000");
      for (int i = 0; i < 5; i++) begin
         step(0, 16'h0, 0, 0, "hold");
         check("hold15", code_out, 15);
         check("holdv", valid_out, 1);
      end
      step(0, 16'h0, 0, 1, "rel");
      check("rel_idle", valid_out, 0);

      // Empty request: one-cycle zero pulse.
      step(1, 16'h0000, 0, 0, "ld0");
      check("zero_hi", zero_out, 1);
      check("zero_nv", valid_out, 0);
      step(0, 16'h0, 0, 0, "ld0b");
      check("zero_lo", zero_out, 0);

      // Flush beats simultaneous load and transfer.
      step(1, 16'h00F0, 0, 1, "ldF0");
      step(0, 16'h0, 0, 1, "f1");
      check("code5", code_out, 5);
      step(1, 16'h0F00, 1, 1, "flush");
      check("fl_v", valid_out, 0);
      check("fl_cnt", count_out, 0);
      step(0, 16'h0, 0, 1, "fl_after");

      // Load during the final transfer is ignored.
      step(1, 16'h0003, 0, 1, "ld3");
      step(0, 16'h0, 0, 1, "t1");
      step(1, 16'h0004, 0, 1, "lastld");
      check("ign_v", valid_out, 0);
      step(1, 16'h0004, 0, 0, "ld4");
      check("code2", code_out, 2);
      check("cnt1", count_out, 1);
      step(0, 16'h0, 0, 1, "t4");

      // Asynchronous reset in the middle of a drain.
      step(1, 16'hFFFF, 0, 1, "ldFFFF");
      for (int i = 0; i < 3; i++) step(0, 16'h0, 0, 1, "dff");
      check("code3", code_out, 3);
      #2 rstn_in = 1'b0;
      #1;
      model_reset();
      check("ar_v", valid_out, 0);
      check("ar_b", busy_out, 0);
      check("ar_c", count_out, 0);
      check("ar_code", code_out, 0);
      @(negedge clk_in);
      rstn_in = 1'b1;

      // Full vector streams 0..15 back to back.
      step(1, 16'hFFFF, 0, 1, "full");
      for (int i = 0; i < 16; i++) begin
         check("seq", code_out, i);
         step(0, 16'h0, 0, 1, "fulld");
      end

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         logic [15:0] r;
         int sel;
         sel = $urandom_range(0, 9);
         r = 16'($urandom);
         if (sel == 0) r = 16'h0;
         else if (sel == 1) r = 16'hFFFF;
         else if (sel < 5) r = r & 16'($urandom) & 16'($urandom);
         step($urandom_range(0, 2) == 0, r, $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) < 7, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
